// File: rtl/mac_rx.sv
// mac_rx: GMII receive MAC. Strips preamble/SFD, filters on destination MAC, streams the payload with the FCS
// withheld through a 4-byte delay line, and flags the CRC-32 / length / rx_er verdict at end of frame.
`default_nettype none

module mac_rx #(
  parameter int MAX_LEN = 1518,
  parameter int MIN_LEN = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        gmii_rx_dv,
  input  logic        gmii_rx_er,
  input  logic [7:0]  gmii_rxd,
  input  logic [47:0] local_mac_addr,
  output logic        mac_rx_start,
  output logic        mac_rx_valid,
  output logic [7:0]  mac_rx_data,
  output logic        mac_rx_end,
  output logic        mac_rx_crc_ok,
  output logic        mac_rx_err,
  output logic        rx_ip_frame,
  output logic        rx_arp_frame,
  output logic [47:0] rx_source_mac
);

  localparam logic [10:0] c_MAX_LEN  = 11'(MAX_LEN);
  localparam logic [10:0] c_MIN_LEN  = 11'(MIN_LEN);
  localparam logic [31:0] c_CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [31:0] c_CRC_GOOD = 32'hDEBB_20E3;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PREAMBLE = 3'd1,
    S_DEST     = 3'd2,
    S_SRC      = 3'd3,
    S_TYPE     = 3'd4,
    S_DATA     = 3'd5,
    S_DROP     = 3'd6
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_dv_d;
  logic [2:0]  r_idx;
  logic [39:0] r_dest;
  logic [47:0] r_src_tmp;
  logic [7:0]  r_type_hi;
  logic [31:0] r_dl;
  logic [2:0]  r_dl_cnt;
  logic [10:0] r_count;
  logic [31:0] r_crc;
  logic        r_er_seen;

  logic [47:0] w_dest_full;
  logic [15:0] w_type;
  logic        w_dest_match;
  logic        w_type_ok;
  logic [10:0] w_count_inc;
  logic        w_oversize;
  logic        w_sfd;
  logic        w_in_frame;
  logic        w_good;

  // Reflected CRC-32, one byte LSB first, no final inversion.
  function automatic logic [31:0] f_crc_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = (c[0] ^ d[i]) ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return c;
  endfunction

  always_comb begin
    w_dest_full  = {r_dest, gmii_rxd};
    w_type       = {r_type_hi, gmii_rxd};
    w_dest_match = (w_dest_full == local_mac_addr) || (w_dest_full == 48'hFFFF_FFFF_FFFF);
    w_type_ok    = (w_type == 16'h0800) || (w_type == 16'h0806);
    w_count_inc  = (r_count == 11'h7FF) ? r_count : r_count + 11'd1;
    w_oversize   = (w_count_inc > c_MAX_LEN);
    w_good       = (r_crc == c_CRC_GOOD) && (r_count >= c_MIN_LEN) && !r_er_seen;
    w_in_frame   = (r_state == S_DEST) || (r_state == S_SRC) || (r_state == S_TYPE) || (r_state == S_DATA);
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        // Only a dv rising edge starts a frame, so a reset released mid-frame waits for the next one.
        if (gmii_rx_dv && !r_dv_d) begin
          if (gmii_rxd == 8'h55)      w_state_nxt = S_PREAMBLE;
          else if (gmii_rxd == 8'hD5) w_state_nxt = S_DEST;
          else                        w_state_nxt = S_DROP;
        end
      end
      S_PREAMBLE: begin
        if (!gmii_rx_dv)             w_state_nxt = S_IDLE;
        else if (gmii_rxd == 8'hD5)  w_state_nxt = S_DEST;
        else if (gmii_rxd != 8'h55)  w_state_nxt = S_DROP;
      end
      S_DEST: begin
        if (!gmii_rx_dv)             w_state_nxt = S_IDLE;
        else if (gmii_rx_er)         w_state_nxt = S_DROP;
        else if (r_idx == 3'd5)      w_state_nxt = w_dest_match ? S_SRC : S_DROP;
      end
      S_SRC: begin
        if (!gmii_rx_dv)             w_state_nxt = S_IDLE;
        else if (gmii_rx_er)         w_state_nxt = S_DROP;
        else if (r_idx == 3'd5)      w_state_nxt = S_TYPE;
      end
      S_TYPE: begin
        if (!gmii_rx_dv)             w_state_nxt = S_IDLE;
        else if (gmii_rx_er)         w_state_nxt = S_DROP;
        else if (r_idx == 3'd1)      w_state_nxt = w_type_ok ? S_DATA : S_DROP;
      end
      S_DATA: begin
        if (!gmii_rx_dv)             w_state_nxt = S_IDLE;
        else if (w_oversize)         w_state_nxt = S_DROP;
      end
      S_DROP: begin
        if (!gmii_rx_dv)             w_state_nxt = S_IDLE;
      end
      default:                       w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_sfd = ((r_state == S_IDLE) || (r_state == S_PREAMBLE)) && (w_state_nxt == S_DEST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dv_d        <= 1'b1;
      r_idx         <= 3'd0;
      r_dest        <= '0;
      r_src_tmp     <= '0;
      r_type_hi     <= '0;
      r_dl          <= '0;
      r_dl_cnt      <= 3'd0;
      r_count       <= '0;
      r_crc         <= c_CRC_INIT;
      r_er_seen     <= 1'b0;
      mac_rx_start  <= 1'b0;
      mac_rx_valid  <= 1'b0;
      mac_rx_data   <= '0;
      mac_rx_end    <= 1'b0;
      mac_rx_crc_ok <= 1'b0;
      mac_rx_err    <= 1'b0;
      rx_ip_frame   <= 1'b0;
      rx_arp_frame  <= 1'b0;
      rx_source_mac <= '0;
    end else begin
      r_dv_d        <= gmii_rx_dv;
      mac_rx_start  <= 1'b0;
      mac_rx_valid  <= 1'b0;
      mac_rx_end    <= 1'b0;
      mac_rx_crc_ok <= 1'b0;
      mac_rx_err    <= 1'b0;
      r_idx         <= (w_state_nxt != r_state) ? 3'd0 : r_idx + 3'd1;

      if (mac_rx_end) begin
        rx_ip_frame  <= 1'b0;
        rx_arp_frame <= 1'b0;
      end

      if (w_sfd) begin
        r_crc     <= c_CRC_INIT;
        r_count   <= '0;
        r_er_seen <= 1'b0;
      end else if (w_in_frame && gmii_rx_dv) begin
        r_crc   <= f_crc_byte(r_crc, gmii_rxd);
        r_count <= w_count_inc;
        if (gmii_rx_er) r_er_seen <= 1'b1;
      end

      case (r_state)
        S_DEST: r_dest    <= {r_dest[31:0], gmii_rxd};
        S_SRC:  r_src_tmp <= {r_src_tmp[39:0], gmii_rxd};
        S_TYPE: begin
          r_type_hi <= gmii_rxd;
          if (w_state_nxt == S_DATA) begin
            mac_rx_start  <= 1'b1;
            rx_source_mac <= r_src_tmp;
            rx_ip_frame   <= (w_type == 16'h0800);
            rx_arp_frame  <= (w_type == 16'h0806);
            r_dl_cnt      <= 3'd0;
          end
        end
        S_DATA: begin
          if (!gmii_rx_dv) begin
            mac_rx_end    <= 1'b1;
            mac_rx_crc_ok <= w_good;
            mac_rx_err    <= !w_good;
          end else if (w_oversize) begin
            mac_rx_end <= 1'b1;
            mac_rx_err <= 1'b1;
          end else begin
            // Oldest of four buffered bytes leaves only once a fifth arrives, so the FCS never escapes.
            r_dl <= {r_dl[23:0], gmii_rxd};
            if (r_dl_cnt == 3'd4) begin
              mac_rx_valid <= 1'b1;
              mac_rx_data  <= r_dl[31:24];
            end else begin
              r_dl_cnt <= r_dl_cnt + 3'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mac_rx.sv
// tb_mac_rx: table-driven frame vectors plus hand sequences for mid-frame reset and back-to-back frames.
`default_nettype none

module tb_mac_rx;

  logic        clk;
  logic        rst;
  logic        gmii_rx_dv;
  logic        gmii_rx_er;
  logic [7:0]  gmii_rxd;
  logic [47:0] local_mac_addr;
  logic        mac_rx_start;
  logic        mac_rx_valid;
  logic [7:0]  mac_rx_data;
  logic        mac_rx_end;
  logic        mac_rx_crc_ok;
  logic        mac_rx_err;
  logic        rx_ip_frame;
  logic        rx_arp_frame;
  logic [47:0] rx_source_mac;

  mac_rx dut (
    .clk            (clk),
    .rst            (rst),
    .gmii_rx_dv     (gmii_rx_dv),
    .gmii_rx_er     (gmii_rx_er),
    .gmii_rxd       (gmii_rxd),
    .local_mac_addr (local_mac_addr),
    .mac_rx_start   (mac_rx_start),
    .mac_rx_valid   (mac_rx_valid),
    .mac_rx_data    (mac_rx_data),
    .mac_rx_end     (mac_rx_end),
    .mac_rx_crc_ok  (mac_rx_crc_ok),
    .mac_rx_err     (mac_rx_err),
    .rx_ip_frame    (rx_ip_frame),
    .rx_arp_frame   (rx_arp_frame),
    .rx_source_mac  (rx_source_mac)
  );

  initial clk = 1'b0;
  always #4 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge.
  int   m_start = 0, m_valid = 0, m_end = 0, m_okcnt = 0, m_bad = 0, m_viol = 0, m_vidx = 0;
  logic m_win = 1'b0, m_ok = 1'b0, m_err = 1'b0, m_ip = 1'b0, m_arp = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      m_win <= 1'b0;
    end else begin
      m_viol <= m_viol + int'(mac_rx_start && m_win) + int'(mac_rx_valid && !m_win && !mac_rx_start)
                       + int'((mac_rx_crc_ok || mac_rx_err) && !mac_rx_end);
      if (mac_rx_start) begin
        m_start <= m_start + 1;
        m_win   <= 1'b1;
        m_vidx  <= 0;
      end
      if (mac_rx_valid) begin
        if (mac_rx_data !== m_vidx[7:0]) m_bad <= m_bad + 1;
        m_vidx  <= m_vidx + 1;
        m_valid <= m_valid + 1;
      end
      if (mac_rx_end) begin
        m_end   <= m_end + 1;
        m_okcnt <= m_okcnt + int'(mac_rx_crc_ok);
        m_ok    <= mac_rx_crc_ok;
        m_err   <= mac_rx_err;
        m_ip    <= rx_ip_frame;
        m_arp   <= rx_arp_frame;
        m_win   <= 1'b0;
      end
    end
  end

  logic [7:0] q[$];

  function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ 32'hEDB8_8320;
      else             c = c >> 1;
    end
    return c;
  endfunction

  task automatic build_frame(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] et,
                             input int plen, input bit bad_fcs);
    logic [31:0] crc;
    logic [31:0] fcs;
    int          last;
    q.delete();
    repeat (7) q.push_back(8'h55);
    q.push_back(8'hD5);
    for (int i = 0; i < 6; i++) q.push_back(dst[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) q.push_back(src[47-8*i -: 8]);
    q.push_back(et[15:8]);
    q.push_back(et[7:0]);
    for (int i = 0; i < plen; i++) q.push_back(i[7:0]);
    crc = 32'hFFFF_FFFF;
    for (int i = 8; i < q.size(); i++) crc = crc_byte(crc, q[i]);
    fcs = ~crc;
    q.push_back(fcs[7:0]);
    q.push_back(fcs[15:8]);
    q.push_back(fcs[23:16]);
    q.push_back(fcs[31:24]);
    if (bad_fcs) begin
      last    = q.size() - 1;
      q[last] = q[last] ^ 8'hFF;
    end
  endtask

  task automatic send_frame(input int er_idx, input int gap);
    for (int i = 0; i < q.size(); i++) begin
      @(posedge clk); #1;
      gmii_rx_dv = 1'b1;
      gmii_rxd   = q[i];
      gmii_rx_er = (i == er_idx);
    end
    @(posedge clk); #1;
    gmii_rx_dv = 1'b0;
    gmii_rxd   = 8'h00;
    gmii_rx_er = 1'b0;
    repeat (gap - 1) @(posedge clk);
  endtask

  typedef struct {
    logic [47:0] dest;
    logic [47:0] src;
    logic [15:0] etype;
    int          plen;
    bit          bad_fcs;
    int          er_at;
    int          exp_start;
    int          exp_valid;
    int          exp_end;
    bit          exp_ok;
    bit          exp_err;
    bit          exp_ip;
    bit          exp_arp;
  } vec_t;

  localparam logic [47:0] LOCAL = 48'h000A_3501_FEC0;
  localparam logic [47:0] SRC1  = 48'h0211_2233_4455;
  localparam logic [47:0] SRC2  = 48'h02AA_BBCC_DDEE;
  localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;

  vec_t        vecs[9];
  logic [47:0] exp_src;
  int          s_start, s_valid, s_end, s_bad, s_viol, s_ok;

  task automatic snap();
    s_start = m_start; s_valid = m_valid; s_end = m_end;
    s_bad = m_bad; s_viol = m_viol; s_ok = m_okcnt;
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; gmii_rx_dv = 1'b0; gmii_rx_er = 1'b0; gmii_rxd = 8'h00;
    local_mac_addr = LOCAL;
    exp_src = '0;

    //            dest          src   type      plen bad er  st  valid end ok err ip arp
    vecs[0] = '{LOCAL,          SRC1, 16'h0800, 46,  0, -1, 1,  46,   1,  1, 0,  1, 0};
    vecs[1] = '{BCAST,          SRC2, 16'h0806, 46,  0, -1, 1,  46,   1,  1, 0,  0, 1};
    vecs[2] = '{LOCAL,          SRC1, 16'h0800, 46,  1, -1, 1,  46,   1,  0, 1,  1, 0};
    vecs[3] = '{48'h000A3501FEC1, SRC2, 16'h0800, 46, 0, -1, 0,  0,   0,  0, 0,  0, 0};
    vecs[4] = '{LOCAL,          SRC2, 16'h86DD, 46,  0, -1, 0,  0,    0,  0, 0,  0, 0};
    vecs[5] = '{LOCAL,          SRC2, 16'h0800, 22,  0, -1, 1,  22,   1,  0, 1,  1, 0};
    vecs[6] = '{LOCAL,          SRC1, 16'h0800, 46,  0, 10, 1,  46,   1,  0, 1,  1, 0};
    vecs[7] = '{LOCAL,          SRC2, 16'h0800, 1582, 0, -1, 1, 1500, 1,  0, 1,  1, 0};
    vecs[8] = '{LOCAL,          SRC1, 16'h0806, 100, 0, -1, 1,  100,  1,  1, 0,  0, 1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_valid", mac_rx_valid, 0);
    check("reset_start", mac_rx_start, 0);
    check("reset_end",   mac_rx_end,   0);
    check("reset_flags", {rx_ip_frame, rx_arp_frame, mac_rx_crc_ok, mac_rx_err}, 0);
    check("reset_srcmac", rx_source_mac, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) @(posedge clk);

    for (int v = 0; v < 9; v++) begin
      snap();
      build_frame(vecs[v].dest, vecs[v].src, vecs[v].etype, vecs[v].plen, vecs[v].bad_fcs);
      send_frame((vecs[v].er_at < 0) ? -1 : 22 + vecs[v].er_at, 10);
      if (vecs[v].exp_start != 0) exp_src = vecs[v].src;
      check($sformatf("v%0d_start", v), m_start - s_start, vecs[v].exp_start);
      check($sformatf("v%0d_valid", v), m_valid - s_valid, vecs[v].exp_valid);
      check($sformatf("v%0d_end",   v), m_end - s_end,     vecs[v].exp_end);
      check($sformatf("v%0d_data",  v), m_bad - s_bad,     0);
      check($sformatf("v%0d_window", v), m_viol - s_viol,  0);
      check($sformatf("v%0d_srcmac", v), rx_source_mac,    exp_src);
      check($sformatf("v%0d_flags_clear", v), {rx_ip_frame, rx_arp_frame}, 0);
      if (vecs[v].exp_end != 0) begin
        check($sformatf("v%0d_crc_ok", v), m_ok,  vecs[v].exp_ok);
        check($sformatf("v%0d_err",    v), m_err, vecs[v].exp_err);
        check($sformatf("v%0d_ip",     v), m_ip,  vecs[v].exp_ip);
        check($sformatf("v%0d_arp",    v), m_arp, vecs[v].exp_arp);
      end
    end

    // Back-to-back frames with a single idle cycle between them.
    snap();
    build_frame(LOCAL, SRC1, 16'h0800, 46, 0);
    send_frame(-1, 1);
    send_frame(-1, 10);
    check("b2b_start", m_start - s_start, 2);
    check("b2b_end",   m_end - s_end,     2);
    check("b2b_ok",    m_okcnt - s_ok,    2);
    check("b2b_valid", m_valid - s_valid, 92);
    check("b2b_order", m_viol - s_viol,   0);

    // Asynchronous reset in the middle of a payload, released while dv is still high.
    snap();
    build_frame(LOCAL, SRC2, 16'h0800, 46, 0);
    for (int i = 0; i < q.size(); i++) begin
      @(posedge clk); #1;
      gmii_rx_dv = 1'b1;
      gmii_rxd   = q[i];
      if (i == 43) rst = 1'b0;
      if (i == 42) begin
        check("pre_rst_ip", rx_ip_frame, 1);
        #2 rst = 1'b1;
        #1;
        check("rst_async_valid", mac_rx_valid, 0);
        check("rst_async_ip",    rx_ip_frame,  0);
        check("rst_async_srcmac", rx_source_mac, 0);
        snap();
      end
    end
    @(posedge clk); #1 gmii_rx_dv = 1'b0; gmii_rxd = 8'h00;
    repeat (10) @(posedge clk);
    check("rst_no_end",   m_end - s_end,     0);
    check("rst_no_valid", m_valid - s_valid, 0);
    check("rst_no_start", m_start - s_start, 0);

    snap();
    build_frame(LOCAL, SRC1, 16'h0806, 46, 0);
    send_frame(-1, 10);
    check("recover_ok",    m_okcnt - s_ok, 1);
    check("recover_valid", m_valid - s_valid, 46);
    check("recover_srcmac", rx_source_mac, SRC1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
